// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, and feeds IF/ID through a 1-entry skid.
// Optional FETCH_PERF_CNT_EN adds consumed-instruction and stalled-cycle counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        flush_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic        r_skid_valid;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        r_inst_valid;
  logic        r_flush;

  logic        w_req;
  logic        w_ack;
  logic        w_take;
  logic        w_consume;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_ack      = w_req & imem_ack_i;
  assign w_take     = w_ack & (r_state == S_FETCH) & ~redirect_i;
  assign w_consume  = r_inst_valid & ~stall_i;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = redirect_addr_i & ~32'd3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (redirect_i)
          w_next_state = (w_req && !imem_ack_i) ? S_DROP : S_FETCH;
        else if (w_take && r_inst_valid && !w_consume)
          w_next_state = S_HOLD;
      end
      S_HOLD:  if (redirect_i || w_consume) w_next_state = S_FETCH;
      S_DROP:  if (w_ack) w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // r_run keeps req low for the first cycle out of reset.
  always_comb begin
    w_req       = r_run && (r_state != S_HOLD);
    imem_addr_o = (r_state == S_DROP) ? r_drop_addr : r_pc;
    imem_req_o  = w_req;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run        <= 1'b0;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_INST;
      r_skid_addr  <= 32'd0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= 32'd0;
      r_inst_valid <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_flush <= redirect_i;
      if (redirect_i) begin
        // The un-acked request keeps its old address until the memory answers.
        if (r_state == S_FETCH) r_drop_addr <= r_pc;
        r_pc         <= w_target;
        r_inst       <= NOP_INST;
        r_inst_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        if (w_take) r_pc <= w_pc_plus4;
        if (r_skid_valid) begin
          if (w_consume) begin
            r_inst       <= r_skid_data;
            r_inst_addr  <= r_skid_addr;
            r_skid_valid <= 1'b0;
          end
        end else if (w_take) begin
          if (!r_inst_valid || w_consume) begin
            r_inst       <= imem_data_i;
            r_inst_addr  <= w_pc_plus4;
            r_inst_valid <= 1'b1;
          end else begin
            r_skid_data  <= imem_data_i;
            r_skid_addr  <= w_pc_plus4;
            r_skid_valid <= 1'b1;
          end
        end else if (w_consume) begin
          r_inst       <= NOP_INST;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;
  assign flush_o      = r_flush;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_consume)                r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (stall_i && r_inst_valid)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
